// File: rtl/up_counter_pkg.sv
// Shared defaults and helpers for the up_counter_design slice.
package up_counter_pkg;

  localparam int COUNT_W_DEF = 4;
  localparam int WRAP_W_DEF  = 8;

  // Increment that sticks at the all-ones value of a width-bit field.
  function automatic logic [31:0] inc_sat(input logic [31:0] value, input int unsigned width);
    logic [31:0] all_ones;
    if (width >= 32'd32) begin
      all_ones = 32'hFFFF_FFFF;
    end else begin
      all_ones = (32'd1 << width) - 32'd1;
    end
    if (value >= all_ones) begin
      inc_sat = all_ones;
    end else begin
      inc_sat = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/up_counter_wrap_tracker.sv
// Saturating event counter that tallies counter wraps since the last reset.
module up_counter_wrap_tracker
  import up_counter_pkg::*;
#(
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrap_evt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  logic [WRAP_W-1:0] wrap_cnt_d;
  logic [WRAP_W-1:0] wrap_cnt_q;

  // Next tally: bump on each wrap event, holding once all-ones is reached.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_evt) begin
      wrap_cnt_d = WRAP_W'(inc_sat(32'(wrap_cnt_q), WRAP_W));
    end else begin
      wrap_cnt_d = wrap_cnt_q;
    end
  end

  // Tally register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_cnt_q <= {WRAP_W{1'b0}};
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: rtl/up_counter_design.sv
// Free-running modulo-(MAX_VALUE+1) up counter with terminal-count flag and wrap tally.
// Define UP_COUNTER_SAT_EN to make the counter hold at MAX_VALUE instead of wrapping.
module up_counter_design
  import up_counter_pkg::*;
#(
  parameter int               WIDTH     = COUNT_W_DEF,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter int               WRAP_W    = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  logic             tc_s;
  logic             wrap_evt_s;

  // Next count, terminal-count decode and wrap event (reset suppresses the event).
  always_comb begin
    tc_s       = (count_q == MAX_VALUE);
    count_d    = count_q;
    wrap_evt_s = 1'b0;
`ifdef UP_COUNTER_SAT_EN
    if (tc_s) begin
      count_d = count_q;
    end else begin
      count_d = count_q + WIDTH'(1'b1);
    end
`else
    if (tc_s) begin
      count_d    = {WIDTH{1'b0}};
      wrap_evt_s = ~reset;
    end else begin
      count_d    = count_q + WIDTH'(1'b1);
      wrap_evt_s = 1'b0;
    end
`endif
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  up_counter_wrap_tracker #(
    .WRAP_W (WRAP_W)
  ) u_wrap_tracker (
    .clk      (clk),
    .reset    (reset),
    .wrap_evt (wrap_evt_s),
    .wrap_cnt (wrap_cnt)
  );

  assign count = count_q;
  assign tc    = tc_s;

endmodule

// File: tb/tb_up_counter_design.sv
// Scoreboard bench: a default instance (mod 16) and a mod-10 instance with a 2-bit wrap tally.
module tb_up_counter_design;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] c1, c2;
  logic       tc1, tc2;
  logic [7:0] w1;
  logic [1:0] w2;

  always #5 clk = ~clk;

  up_counter_design #(.WIDTH(4), .MAX_VALUE(4'd15), .WRAP_W(8)) dut_a (
    .clk(clk), .reset(reset), .count(c1), .tc(tc1), .wrap_cnt(w1)
  );

  up_counter_design #(.WIDTH(4), .MAX_VALUE(4'd9), .WRAP_W(2)) dut_b (
    .clk(clk), .reset(reset), .count(c2), .tc(tc2), .wrap_cnt(w2)
  );

  typedef struct {
    int    c1, w1, c2, w2;
    bit    hand;
    int    h_c1, h_w1, h_c2, h_w2;
    string tag;
  } exp_t;

  typedef struct {
    bit    r;
    int    n;
    int    h_c1, h_w1, h_c2, h_w2;
    string tag;
  } phase_t;

`ifdef UP_COUNTER_SAT_EN
  localparam bit HAND_EN = 1'b0;
`else
  localparam bit HAND_EN = 1'b1;
`endif

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int m_c1 = 0, m_w1 = 0, m_c2 = 0, m_w2 = 0;

  // Hand-computed state after the last edge of each phase (modulo build).
  phase_t phases[9] = '{
    '{1'b1,  2,  0, 0, 0, 0, "reset"},
    '{1'b0, 48,  0, 3, 8, 3, "wrap3"},
    '{1'b0,  9,  9, 3, 7, 3, "mid9"},
    '{1'b1,  1,  0, 0, 0, 0, "rst_mid"},
    '{1'b0,  1,  1, 0, 1, 0, "resume"},
    '{1'b0, 14, 15, 0, 5, 1, "at15"},
    '{1'b1,  1,  0, 0, 0, 0, "rst_wrap"},
    '{1'b0, 16,  0, 1, 6, 1, "period"},
    '{1'b0,  3,  3, 1, 9, 1, "tc9"}
  };

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input bit r, input bit hand, input phase_t p);
    exp_t e;
    reset = r;
    @(posedge clk);
    if (r) begin
      m_c1 = 0; m_w1 = 0; m_c2 = 0; m_w2 = 0;
    end else begin
`ifdef UP_COUNTER_SAT_EN
      if (m_c1 != 15) m_c1++;
      if (m_c2 != 9) m_c2++;
`else
      if (m_c1 == 15) begin m_c1 = 0; if (m_w1 < 255) m_w1++; end else m_c1++;
      if (m_c2 == 9) begin m_c2 = 0; if (m_w2 < 3) m_w2++; end else m_c2++;
`endif
    end
    e.c1 = m_c1; e.w1 = m_w1; e.c2 = m_c2; e.w2 = m_w2;
    e.hand = hand;
    e.h_c1 = p.h_c1; e.h_w1 = p.h_w1; e.h_c2 = p.h_c2; e.h_w2 = p.h_w2;
    e.tag = p.tag;
    q.push_back(e);
    #1;
  endtask

  // Monitor: the DUT presents a new state every edge; compare it mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk({mon_e.tag, "_count_a"}, int'(c1), mon_e.c1);
      chk({mon_e.tag, "_tc_a"},    int'(tc1), (mon_e.c1 == 15) ? 1 : 0);
      chk({mon_e.tag, "_wrap_a"},  int'(w1), mon_e.w1);
      chk({mon_e.tag, "_count_b"}, int'(c2), mon_e.c2);
      chk({mon_e.tag, "_tc_b"},    int'(tc2), (mon_e.c2 == 9) ? 1 : 0);
      chk({mon_e.tag, "_wrap_b"},  int'(w2), mon_e.w2);
      if (mon_e.hand) begin
        chk({mon_e.tag, "_hand_count_a"}, int'(c1), mon_e.h_c1);
        chk({mon_e.tag, "_hand_wrap_a"},  int'(w1), mon_e.h_w1);
        chk({mon_e.tag, "_hand_count_b"}, int'(c2), mon_e.h_c2);
        chk({mon_e.tag, "_hand_wrap_b"},  int'(w2), mon_e.h_w2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < phases[i].n; k++) begin
        step(phases[i].r, HAND_EN && (k == phases[i].n - 1), phases[i]);
      end
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
